// File: rtl/apb_master_ctrl_pkg.sv
// apb_pkg: shared APB state encoding and strobe-width helper
//   IDLE/SETUP/ACCESS encodings are shared with the APB completer side.
//   strb_w(): byte-strobe width for a given data width.
package apb_pkg;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SETUP  = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    typedef enum logic [1:0] {ST_IDLE = IDLE, ST_SETUP = SETUP, ST_ACCESS = ACCESS} state_t;
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: command/response handshake plus APB bus of the APB requester
//   cmd_*  : command request (valid/ready) with write/addr/wdata/strb payload
//   rsp_*  : single-cycle response strobe with rdata/err/timeout
//   p*     : APB3/APB4 bus signals
//   master : requester view, slave : agent/completer view
interface apb_master_ctrl_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    import apb_pkg::*;
    localparam int STRB_W = strb_w(DATA_W);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, pready, prdata, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata, pstrb
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, pready, prdata, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata, pstrb
    );
endinterface

// File: rtl/apb_master_ctrl_timeout_cnt.sv
// apb_timeout_cnt: ACCESS wait-cycle counter for the APB requester timeout
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : zero the count (on entry to ACCESS)
//   enable     : count one wait cycle
//   expired    : this enabled cycle brings the count to LIMIT
module apb_timeout_cnt #(parameter int LIMIT = 256) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n || clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end
    assign expired = enable && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB requester turning one valid/ready command into one APB transfer
//   clk   : bus clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : apb_master_ctrl_if.master (cmd_*, rsp_*, APB p* signals)
//   Optional macro APB_MASTER_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    apb_master_ctrl_if.master    bus
);
    localparam int STRB_W = strb_w(DATA_W);
    state_t state, state_nxt;
    logic   done, timeout, accept;
    assign done   = state == ST_ACCESS && bus.pready;
    assign accept = state == ST_IDLE && bus.cmd_valid;
`ifdef APB_MASTER_TIMEOUT_EN
    apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_SETUP),
        .enable (state == ST_ACCESS && !bus.pready),
        .expired(timeout)
    );
`else
    // Constant zero that still references the limit so it is not an unused parameter.
    assign timeout = 1'b0 & (|TIMEOUT_CYCLES);
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        bus.cmd_ready = rst_n && state == ST_IDLE;
        bus.psel      = state == ST_SETUP || state == ST_ACCESS;
        bus.penable   = state == ST_ACCESS;
        state_nxt     = state == ST_IDLE   ? (bus.cmd_valid ? ST_SETUP : ST_IDLE) :
                        state == ST_SETUP  ? ST_ACCESS :
                        state == ST_ACCESS && !(done || timeout) ? ST_ACCESS : ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.paddr       <= ADDR_W'(0);
            bus.pwrite      <= 1'b0;
            bus.pwdata      <= DATA_W'(0);
            bus.pstrb       <= STRB_W'(0);
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= DATA_W'(0);
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            bus.rsp_valid <= done || timeout;
            if (accept) begin
                bus.paddr  <= bus.cmd_addr;
                bus.pwrite <= bus.cmd_write;
                bus.pwdata <= bus.cmd_wdata;
                bus.pstrb  <= bus.cmd_write ? bus.cmd_strb : STRB_W'(0);
            end
            // pready wins over a same-cycle timeout because the counter only runs while pready=0.
            if (done) begin
                bus.rsp_rdata   <= bus.pwrite ? DATA_W'(0) : bus.prdata;
                bus.rsp_err     <= bus.pslverr;
                bus.rsp_timeout <= 1'b0;
            end else if (timeout) begin
                bus.rsp_rdata   <= DATA_W'(0);
                bus.rsp_err     <= 1'b1;
                bus.rsp_timeout <= 1'b1;
            end
        end
    end
endmodule
